knn_topk_sorter: RTL and testbench

Streaming top-K insertion sorter for the KNN accelerator: consumes (name, distance) pairs from the distance stage, keeps the K best entries in sorted order, then drains them best-first over a valid/ready stream to the voting/readout stage. Successor to the phase-2 sorter, with these additions:
- parametrised name width and selection mode
- per-slot valid bits instead of all-ones sentinels
- stable tie ordering
- frame delimiting via `in_last`
- back-pressured output
- synchronous clear

---
 rtl/knn_pkg.sv | 25 ++
 rtl/knn_topk_sorter_if.sv | 38 +++
 rtl/knn_sort_slot.sv | 60 ++++++
 rtl/knn_topk_sorter.sv | 157 +++++++++++++++
 tb/tb_knn_topk_sorter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/knn_pkg.sv
// Shared definitions for the KNN top-K sorter: selection modes, FSM state
// encoding and the ordering predicate used by every slot.
package knn_pkg;

    localparam int MODE_NEAREST  = 0;
    localparam int MODE_FARTHEST = 1;

    // Widest distance the ordering predicate handles.
    localparam int MAX_VAL_WIDTH = 64;

    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        DRAIN  = 1'b1
    } state_t;

    // Strict ordering: an equal value is never better, so ties keep arrival order.
    function automatic logic better(
        input logic [MAX_VAL_WIDTH-1:0] a,
        input logic [MAX_VAL_WIDTH-1:0] b,
        input logic                     mode
    );
        return mode ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/knn_topk_sorter_if.sv
// Sample input stream and sorted-entry output stream of the top-K sorter.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer holds valid and its payload stable until that edge;
// ready may change freely and never depends combinationally on valid.
interface knn_topk_sorter_if #(
    parameter int NAME_WIDTH = 32,
    parameter int VAL_WIDTH  = 32,
    parameter int K          = 8
);
    localparam int RW = $clog2(K) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [NAME_WIDTH-1:0] in_name;
    logic [VAL_WIDTH-1:0]  in_value;
    logic                  in_last;

    logic                  out_valid;
    logic                  out_ready;
    logic [NAME_WIDTH-1:0] out_name;
    logic [VAL_WIDTH-1:0]  out_value;
    logic [RW-1:0]         out_rank;
    logic                  out_last;

    // Distance stage and readout stage side.
    modport master (
        output in_valid, in_name, in_value, in_last, out_ready,
        input  in_ready, out_valid, out_name, out_value, out_rank, out_last
    );

    // Sorter side.
    modport slave (
        input  in_valid, in_name, in_value, in_last, out_ready,
        output in_ready, out_valid, out_name, out_value, out_rank, out_last
    );

endinterface

// File: rtl/knn_sort_slot.sv
// One entry of the insertion-sort table. A slot "takes" a new sample when it
// is empty or the sample beats its content; it then loads either the new
// sample (it is the insertion point) or its upper neighbour (shift down).
module knn_sort_slot
    import knn_pkg::*;
#(
    parameter int NAME_WIDTH = 32,
    parameter int VAL_WIDTH  = 32,
    parameter int MODE       = MODE_NEAREST
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic                  i_take_prev,
    input  logic                  i_prev_valid,
    input  logic [NAME_WIDTH-1:0] i_prev_name,
    input  logic [VAL_WIDTH-1:0]  i_prev_value,
    input  logic [NAME_WIDTH-1:0] i_new_name,
    input  logic [VAL_WIDTH-1:0]  i_new_value,
    output logic                  o_take,
    output logic                  o_valid,
    output logic [NAME_WIDTH-1:0] o_name,
    output logic [VAL_WIDTH-1:0]  o_value
);

    logic                  r_valid;
    logic [NAME_WIDTH-1:0] r_name;
    logic [VAL_WIDTH-1:0]  r_value;
    logic                  w_better;
    logic                  w_update;

    assign w_better = better(MAX_VAL_WIDTH'(i_new_value), MAX_VAL_WIDTH'(r_value), 1'(MODE));
    assign o_take   = !r_valid || w_better;
    assign w_update = i_load && o_take;

    // Valid bit: a shifted slot inherits its neighbour's valid so empty tail slots stay empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_update) begin
            r_valid <= i_take_prev ? i_prev_valid : 1'b1;
        end
    end

    // Payload registers carry no reset; they are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (w_update) begin
            r_name  <= i_take_prev ? i_prev_name  : i_new_name;
            r_value <= i_take_prev ? i_prev_value : i_new_value;
        end
    end

    assign o_valid = r_valid;
    assign o_name  = r_name;
    assign o_value = r_value;

endmodule

// File: rtl/knn_topk_sorter.sv
// Streaming top-K sorter: inserts one (name, distance) sample per cycle into a
// K-deep sorted table, and after the frame's last sample drains the retained
// entries best-first with back-pressure.
module knn_topk_sorter
    import knn_pkg::*;
#(
    parameter int NAME_WIDTH = 32,
    parameter int VAL_WIDTH  = 32,
    parameter int K          = 8,
    parameter int MODE       = MODE_NEAREST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    knn_topk_sorter_if.slave  bus,
    output logic [$clog2(K):0] count,
    output state_t            o_dbg_state
);

    localparam int RW = $clog2(K) + 1;

    state_t                r_state;
    logic [RW-1:0]         r_rp;
    logic [RW-1:0]         r_count;
    logic                  r_in_ready;
    logic                  r_out_valid;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_out_last;
    logic                  w_flush;
    logic [K-1:0]          w_take;
    logic [K-1:0]          w_valid;
    logic [K-1:0]          w_take_prev;
    logic [K-1:0]          w_prev_valid;
    logic [NAME_WIDTH-1:0] w_name       [K];
    logic [VAL_WIDTH-1:0]  w_value      [K];
    logic [NAME_WIDTH-1:0] w_prev_name  [K];
    logic [VAL_WIDTH-1:0]  w_prev_value [K];
    logic [NAME_WIDTH-1:0] w_out_name;
    logic [VAL_WIDTH-1:0]  w_out_value;

    // clear wins over any transfer in the same cycle.
    assign w_in_fire  = bus.in_valid && r_in_ready && !clear;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_out_last = r_out_valid && (r_rp == (r_count - RW'(1)));
    assign w_flush    = clear || (w_out_fire && w_out_last);

    for (genvar i = 0; i < K; i++) begin : g_slot
        if (i == 0) begin : g_head
            assign w_take_prev[i]  = 1'b0;
            assign w_prev_valid[i] = 1'b0;
            assign w_prev_name[i]  = bus.in_name;
            assign w_prev_value[i] = bus.in_value;
        end else begin : g_chain
            assign w_take_prev[i]  = w_take[i-1];
            assign w_prev_valid[i] = w_valid[i-1];
            assign w_prev_name[i]  = w_name[i-1];
            assign w_prev_value[i] = w_value[i-1];
        end

        knn_sort_slot #(
            .NAME_WIDTH (NAME_WIDTH),
            .VAL_WIDTH  (VAL_WIDTH),
            .MODE       (MODE)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .i_load       (w_in_fire),
            .i_flush      (w_flush),
            .i_take_prev  (w_take_prev[i]),
            .i_prev_valid (w_prev_valid[i]),
            .i_prev_name  (w_prev_name[i]),
            .i_prev_value (w_prev_value[i]),
            .i_new_name   (bus.in_name),
            .i_new_value  (bus.in_value),
            .o_take       (w_take[i]),
            .o_valid      (w_valid[i]),
            .o_name       (w_name[i]),
            .o_value      (w_value[i])
        );
    end

    // Read mux: present the slot addressed by the drain pointer.
    always_comb begin
        w_out_name  = '0;
        w_out_value = '0;
        for (int i = 0; i < K; i++) begin
            if (r_rp == RW'(i)) begin
                w_out_name  = w_name[i];
                w_out_value = w_value[i];
            end
        end
    end

    // Control FSM: fill count, drain pointer and the two handshake flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ACCEPT;
            r_rp        <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= ACCEPT;
            r_rp        <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCEPT: begin
                    if (w_in_fire) begin
                        // Retained into a free slot: the table grows by one.
                        if (w_take[K-1] && !w_valid[K-1]) begin
                            r_count <= r_count + RW'(1);
                        end
                        if (bus.in_last) begin
                            r_state     <= DRAIN;
                            r_rp        <= '0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (w_out_last) begin
                            r_state     <= ACCEPT;
                            r_rp        <= '0;
                            r_count     <= '0;
                            r_in_ready  <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_rp <= r_rp + RW'(1);
                        end
                    end
                end
                default: begin
                    r_state     <= ACCEPT;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_name  = w_out_name;
    assign bus.out_value = w_out_value;
    assign bus.out_rank  = r_rp;
    assign bus.out_last  = w_out_last;
    assign count         = r_count;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_knn_topk_sorter.sv
// Bench for knn_topk_sorter: four instances (K=4/3/8 nearest, K=2 farthest)
// driven one at a time by directed frames; a reference insertion model fills
// the expected queue and the drain loop pops and compares each entry.
module tb_knn_topk_sorter;
    import knn_pkg::*;

    localparam int ND = 4;

    function automatic int k_of(input int d);
        case (d)
            0:       return 4;
            1:       return 3;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int m_of(input int d);
        return (d == 3) ? 1 : 0;
    endfunction

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- per-instance drive / monitor ----------------
    logic [ND-1:0] clear_d, in_valid_d, in_last_d, out_ready_d;
    logic [31:0]   in_name_d   [ND];
    logic [31:0]   in_value_d  [ND];
    logic [ND-1:0] in_ready_m, out_valid_m, out_last_m, dbg_m;
    logic [31:0]   out_name_m  [ND];
    logic [31:0]   out_value_m [ND];
    logic [7:0]    out_rank_m  [ND];
    logic [7:0]    count_m     [ND];

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int KK = k_of(g);
        localparam int MM = m_of(g);
        logic [$clog2(KK):0] w_count;
        state_t              w_state;

        knn_topk_sorter_if #(.NAME_WIDTH(32), .VAL_WIDTH(32), .K(KK)) bus ();

        assign bus.in_valid  = in_valid_d[g];
        assign bus.in_name   = in_name_d[g];
        assign bus.in_value  = in_value_d[g];
        assign bus.in_last   = in_last_d[g];
        assign bus.out_ready = out_ready_d[g];

        assign in_ready_m[g]  = bus.in_ready;
        assign out_valid_m[g] = bus.out_valid;
        assign out_last_m[g]  = bus.out_last;
        assign out_name_m[g]  = bus.out_name;
        assign out_value_m[g] = bus.out_value;
        assign out_rank_m[g]  = 8'(bus.out_rank);
        assign count_m[g]     = 8'(w_count);
        assign dbg_m[g]       = (w_state == DRAIN);

        knn_topk_sorter #(
            .NAME_WIDTH (32),
            .VAL_WIDTH  (32),
            .K          (KK),
            .MODE       (MM)
        ) u_dut (
            .clk         (clk),
            .reset       (rst_n),
            .clear       (clear_d[g]),
            .bus         (bus.slave),
            .count       (w_count),
            .o_dbg_state (w_state)
        );
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] ref_q[$];
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit tb_better(input logic [31:0] a, input logic [31:0] b, input int mode);
        return (mode == 1) ? (a > b) : (a < b);
    endfunction

    // Reference: keep a sorted list, insert before the first strictly worse entry.
    task automatic model_insert(input int d, input logic [31:0] name, input logic [31:0] value);
        int          p;
        logic [63:0] ent;
        p = ref_q.size();
        for (int i = ref_q.size() - 1; i >= 0; i--) begin
            ent = ref_q[i];
            if (tb_better(value, ent[31:0], m_of(d))) p = i;
        end
        if (p < k_of(d)) begin
            ref_q.insert(p, {name, value});
            if (ref_q.size() > k_of(d)) ref_q.delete(ref_q.size() - 1);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input int d, input logic [31:0] name, input logic [31:0] value, input bit last);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready_m[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_accept", 64'(in_ready_m[d]), 64'(1));
        check("count_fill", 64'(count_m[d]), 64'(ref_q.size()));
        in_valid_d[d] = 1'b1;
        in_name_d[d]  = name;
        in_value_d[d] = value;
        in_last_d[d]  = last;
        model_insert(d, name, value);
        if (last) begin
            foreach (ref_q[i]) exp_q.push_back(ref_q[i]);
            ref_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // pat 0: out_ready always high; pat 1: 1,0,0 repeating.
    // junk: keep a bogus sample offered during the drain (must never be taken).
    // abort_at: rank whose handshake is hit by clear (kind 0) or reset (kind 1).
    task automatic drain(input int d, input int pat, input bit junk, input int abort_at, input int abort_kind);
        int          n_total, rank, cyc;
        bit          done, held, rdy;
        logic [63:0] held_v, e;
        n_total = exp_q.size();
        rank = 0; cyc = 0; done = 0; held = 0; held_v = '0;
        @(negedge clk);
        in_last_d[d]  = 1'b0;
        in_valid_d[d] = junk;
        in_name_d[d]  = 32'hdead;
        in_value_d[d] = 32'h0;
        while (!done && cyc < 200) begin
            check("drain_out_valid", 64'(out_valid_m[d]), 64'(1));
            check("drain_in_ready", 64'(in_ready_m[d]), 64'(0));
            check("drain_state", 64'(dbg_m[d]), 64'(1));
            check("drain_count", 64'(count_m[d]), 64'(n_total));
            if (held) begin
                check("stall_hold", {out_name_m[d], out_value_m[d]}, held_v);
                check("stall_rank", 64'(out_rank_m[d]), 64'(rank));
            end
            rdy = (pat == 0) || (cyc % 3 == 0);
            out_ready_d[d] = rdy;
            if (rdy) begin
                e = exp_q.pop_front();
                check("out_name", 64'(out_name_m[d]), 64'(e[63:32]));
                check("out_value", 64'(out_value_m[d]), 64'(e[31:0]));
                check("out_rank", 64'(out_rank_m[d]), 64'(rank));
                check("out_last", 64'(out_last_m[d]), 64'(rank == n_total - 1));
                held = 0;
                if (rank == abort_at) begin
                    if (abort_kind == 0) clear_d[d] = 1'b1;
                    else rst_n = 1'b0;
                    done = 1;
                end
                rank++;
                if (rank == n_total) done = 1;
            end else begin
                held   = 1;
                held_v = {out_name_m[d], out_value_m[d]};
            end
            cyc++;
            @(negedge clk);
        end
        check("drain_timeout", 64'(done), 64'(1));
        out_ready_d[d] = 1'b0;
        in_valid_d[d]  = 1'b0;
        clear_d[d]     = 1'b0;
        rst_n          = 1'b1;
        exp_q.delete();
        check("post_out_valid", 64'(out_valid_m[d]), 64'(0));
        check("post_out_last", 64'(out_last_m[d]), 64'(0));
        check("post_in_ready", 64'(in_ready_m[d]), 64'(1));
        check("post_count", 64'(count_m[d]), 64'(0));
        check("post_rank", 64'(out_rank_m[d]), 64'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          len;
        logic [31:0] v;
        rst_n       = 1'b0;
        clear_d     = '0;
        in_valid_d  = '0;
        in_last_d   = '0;
        out_ready_d = '0;
        for (int d = 0; d < ND; d++) begin
            in_name_d[d]  = '0;
            in_value_d[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check("rst_in_ready", 64'(in_ready_m[d]), 64'(1));
            check("rst_out_valid", 64'(out_valid_m[d]), 64'(0));
            check("rst_out_last", 64'(out_last_m[d]), 64'(0));
            check("rst_count", 64'(count_m[d]), 64'(0));
            check("rst_rank", 64'(out_rank_m[d]), 64'(0));
            check("rst_state", 64'(dbg_m[d]), 64'(0));
        end
        rst_n = 1'b1;

        // Basic sort, K=4 nearest: expect (4,10),(2,20),(5,30),(1,50).
        send(0, 1, 50, 0); send(0, 2, 20, 0); send(0, 3, 70, 0);
        send(0, 4, 10, 0); send(0, 5, 30, 1);
        check("basic_exp_len", 64'(exp_q.size()), 64'(4));
        drain(0, 0, 0, -1, 0);

        // Ties, K=3: A,B,C kept in arrival order, D dropped.
        send(1, 32'hA, 7, 0); send(1, 32'hB, 7, 0);
        send(1, 32'hC, 7, 0); send(1, 32'hD, 7, 1);
        drain(1, 0, 0, -1, 0);

        // Short frame, K=8: 3 then 9.
        send(2, 1, 9, 0); send(2, 2, 3, 1);
        drain(2, 0, 0, -1, 0);

        // Single-sample frame.
        send(2, 7, 42, 1);
        drain(2, 0, 1, -1, 0);

        // Farthest mode, K=2: (2,9) then (4,9).
        send(3, 1, 5, 0); send(3, 2, 9, 0); send(3, 3, 1, 0); send(3, 4, 9, 1);
        drain(3, 0, 0, -1, 0);

        // Back-pressure with a bogus sample offered throughout the drain.
        for (int i = 0; i < 6; i++) send(0, 32'(100 + i), 32'($urandom_range(0, 40)), i == 5);
        drain(0, 1, 1, -1, 0);

        // Clear on the second handshake, then a clean frame.
        send(0, 1, 40, 0); send(0, 2, 15, 0); send(0, 3, 15, 0); send(0, 4, 90, 1);
        drain(0, 0, 0, 1, 0);
        send(0, 5, 8, 0); send(0, 6, 3, 0); send(0, 7, 8, 0); send(0, 8, 1, 0); send(0, 9, 2, 1);
        drain(0, 0, 0, -1, 0);

        // Same with reset pulsed instead of clear.
        send(0, 1, 40, 0); send(0, 2, 15, 0); send(0, 3, 15, 0); send(0, 4, 90, 1);
        drain(0, 0, 0, 1, 1);
        send(0, 5, 8, 0); send(0, 6, 3, 0); send(0, 7, 8, 0); send(0, 8, 1, 0); send(0, 9, 2, 1);
        drain(0, 1, 0, -1, 0);

        // Random frames with many ties on the K=3 and farthest instances.
        for (int f = 0; f < 4; f++) begin
            for (int d = 1; d < ND; d += 2) begin
                len = $urandom_range(1, 7);
                for (int i = 0; i < len; i++) begin
                    v = 32'($urandom_range(0, 5));
                    send(d, 32'(16'h100 + i), v, i == len - 1);
                end
                drain(d, $urandom_range(0, 1), 1, -1, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net in case a handshake never completes.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
